ntt_ctrl: RTL and testbench

NTT_CTRL -- requirements
Module: ntt_ctrl

---
 rtl/ntt_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_ntt_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_ctrl.sv
// Sequencer for a 256-point NTT/INTT: 7 layers of 128 butterflies, with write-back aligned L cycles behind reads.
// Define NTT_CTRL_INTT_SCALE_EN to append a 128-issue scaling pass after the last INTT layer.
module ntt_ctrl #(
    parameter int BF_LAT = 3,
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       inv,
    output logic       busy,
    output logic       done,
    output logic       rd_en,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] tw_addr,
    output logic [1:0] bf_mode,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b,
    output logic [2:0] layer
);

    localparam int L  = RD_LAT + BF_LAT;
    localparam int DW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [2:0] {
        st_idle,
        st_issue,
        st_drain,
`ifdef NTT_CTRL_INTT_SCALE_EN
        st_scale,
`endif
        st_done
    } state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] tw;
    } rd_cmd_t;

    typedef struct packed {
        logic       en;
        logic [7:0] a;
        logic [7:0] b;
    } wr_cmd_t;

    // Group length is a power of two, so div/mod by len reduce to shift/mask.
    function automatic rd_cmd_t butterfly_addr(input logic [2:0] l, input logic [6:0] j,
                                               input logic iv);
        logic [2:0] sh;
        logic [7:0] len;
        logic [7:0] mask;
        logic [7:0] base;
        logic [6:0] g;
        logic [6:0] o;
        rd_cmd_t    c;
        sh   = iv ? l + 3'd1 : 3'd7 - l;
        len  = 8'd1 << sh;
        mask = len - 8'd1;
        g    = j >> sh;
        o    = j & mask[6:0];
        base = {1'b0, g} << sh;
        c.a  = (base << 1) | {1'b0, o};
        c.b  = c.a + len;
        c.tw = iv ? 7'((8'd128 >> l) - 8'd1 - {1'b0, g}) : 7'((8'd1 << l) + {1'b0, g});
        return c;
    endfunction

    state_t        state;
    logic [6:0]    j;
    logic [DW-1:0] drain_cnt;
    logic          inv_q;
    logic [6:0]    j_plus;
    rd_cmd_t       cmd_start;
    rd_cmd_t       cmd_next_j;
    rd_cmd_t       cmd_next_layer;
`ifdef NTT_CTRL_INTT_SCALE_EN
    logic          scale_done;
`endif

    assign j_plus         = j + 7'd1;
    assign cmd_start      = butterfly_addr(3'd0, 7'd0, inv);
    assign cmd_next_j     = butterfly_addr(layer, j_plus, inv_q);
    assign cmd_next_layer = butterfly_addr(layer + 3'd1, 7'd0, inv_q);

    // NOTE: every register here updates with <=, so all right-hand sides see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= st_idle;
            j         <= '0;
            drain_cnt <= '0;
            inv_q     <= 1'b0;
            layer     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            bf_mode   <= '0;
`ifdef NTT_CTRL_INTT_SCALE_EN
            scale_done <= 1'b0;
`endif
        end else begin
            case (state)
                st_idle: begin
                    if (start) begin
                        state     <= st_issue;
                        busy      <= 1'b1;
                        inv_q     <= inv;
                        layer     <= '0;
                        j         <= '0;
                        rd_en     <= 1'b1;
                        rd_addr_a <= cmd_start.a;
                        rd_addr_b <= cmd_start.b;
                        tw_addr   <= cmd_start.tw;
                        bf_mode   <= {1'b0, inv};
`ifdef NTT_CTRL_INTT_SCALE_EN
                        scale_done <= 1'b0;
`endif
                    end
                end

                st_issue: begin
                    if (j == 7'd127) begin
                        state     <= st_drain;
                        drain_cnt <= '0;
                        rd_en     <= 1'b0;
                        rd_addr_a <= '0;
                        rd_addr_b <= '0;
                        tw_addr   <= '0;
                        bf_mode   <= '0;
                    end else begin
                        j         <= j_plus;
                        rd_addr_a <= cmd_next_j.a;
                        rd_addr_b <= cmd_next_j.b;
                        tw_addr   <= cmd_next_j.tw;
                    end
                end

                // The drain lets the last write of a layer land before the next layer reads it.
                st_drain: begin
                    if (drain_cnt == DW'(L - 1)) begin
                        if (layer != 3'd6) begin
                            state     <= st_issue;
                            layer     <= layer + 3'd1;
                            j         <= '0;
                            rd_en     <= 1'b1;
                            rd_addr_a <= cmd_next_layer.a;
                            rd_addr_b <= cmd_next_layer.b;
                            tw_addr   <= cmd_next_layer.tw;
                            bf_mode   <= {1'b0, inv_q};
`ifdef NTT_CTRL_INTT_SCALE_EN
                        end else if (inv_q && !scale_done) begin
                            state     <= st_scale;
                            j         <= '0;
                            rd_en     <= 1'b1;
                            rd_addr_a <= 8'd0;
                            rd_addr_b <= 8'd1;
                            tw_addr   <= '0;
                            bf_mode   <= 2'b10;
`endif
                        end else begin
                            state <= st_done;
                            done  <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end

`ifdef NTT_CTRL_INTT_SCALE_EN
                st_scale: begin
                    if (j == 7'd127) begin
                        state      <= st_drain;
                        drain_cnt  <= '0;
                        scale_done <= 1'b1;
                        rd_en      <= 1'b0;
                        rd_addr_a  <= '0;
                        rd_addr_b  <= '0;
                        bf_mode    <= '0;
                    end else begin
                        j         <= j_plus;
                        rd_addr_a <= {j_plus, 1'b0};
                        rd_addr_b <= {j_plus, 1'b1};
                    end
                end
`endif

                st_done: begin
                    state <= st_idle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    layer <= '0;
                end

                default: state <= st_idle;
            endcase
        end
    end

    wr_cmd_t pipe [L];

    // NOTE: the pipeline is reset so an aborted transform cannot leak writes afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{en: rd_en, a: rd_addr_a, b: rd_addr_b};
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign wr_en     = pipe[L-1].en;
    assign wr_addr_a = pipe[L-1].a;
    assign wr_addr_b = pipe[L-1].b;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl (L=4): address/twiddle table, latency, write alignment, busy-start and mid-run reset.
module tb_ntt_ctrl;

    localparam int L    = 4;
    localparam int LOGN = 1100;
`ifdef NTT_CTRL_INTT_SCALE_EN
    localparam int INTT_DONE = 1056;
    localparam int INTT_WR   = 1024;
    localparam int INTT_M2   = 128;
`else
    localparam int INTT_DONE = 924;
    localparam int INTT_WR   = 896;
    localparam int INTT_M2   = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, start, inv;
    logic       busy, done, rd_en, wr_en;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] tw_addr;
    logic [1:0] bf_mode;
    logic [2:0] layer;

    ntt_ctrl #(.BF_LAT(3), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inv(inv),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .bf_mode(bf_mode), .wr_en(wr_en),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .layer(layer)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         iv;
        int         idx;
        bit         rd;
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] tw;
        logic [1:0] mode;
        logic [2:0] lyr;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] b;
    } rdrec_t;

    vec_t   vecs[$];
    rdrec_t q[$];
    rdrec_t e;

    int passed = 0, total = 0;
    int gcyc = 0, acc = 0, mon_idx;
    bit log_on = 0;
    int done_cnt, done_idx, wr_cnt, rd_cnt, align_err, mode2_cnt;
    logic       log_rd   [LOGN];
    logic [7:0] log_a    [LOGN];
    logic [7:0] log_b    [LOGN];
    logic [6:0] log_tw   [LOGN];
    logic [1:0] log_mode [LOGN];
    logic [2:0] log_lyr  [LOGN];

    always @(posedge clk) gcyc <= gcyc + 1;

    // Period index 0 is the cycle right after the edge that accepted start.
    always @(negedge clk) begin
        mon_idx = gcyc - acc;
        if (log_on) begin
            if (mon_idx >= 0 && mon_idx < LOGN) begin
                log_rd[mon_idx]   = rd_en;
                log_a[mon_idx]    = rd_addr_a;
                log_b[mon_idx]    = rd_addr_b;
                log_tw[mon_idx]   = tw_addr;
                log_mode[mon_idx] = bf_mode;
                log_lyr[mon_idx]  = layer;
            end
            if (done) begin
                done_cnt++;
                done_idx = mon_idx;
            end
            if (bf_mode == 2'b10) mode2_cnt++;
            if (wr_en) begin
                wr_cnt++;
                if (q.size() == 0) align_err++;
                else begin
                    e = q.pop_front();
                    if (gcyc - e.cyc != L || e.a !== wr_addr_a || e.b !== wr_addr_b) align_err++;
                end
            end
            if (rd_en) begin
                rd_cnt++;
                q.push_back('{gcyc, rd_addr_a, rd_addr_b});
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void add(bit iv, int idx, bit rd, int a, int b, int tw, int mode, int lyr);
        vec_t v;
        v.iv = iv; v.idx = idx; v.rd = rd;
        v.a = 8'(a); v.b = 8'(b); v.tw = 7'(tw); v.mode = 2'(mode); v.lyr = 3'(lyr);
        vecs.push_back(v);
    endfunction

    task automatic begin_run(input bit iv);
        log_on = 0;
        for (int i = 0; i < LOGN; i++) begin
            log_rd[i] = 1'bx; log_a[i] = 'x; log_b[i] = 'x;
            log_tw[i] = 'x; log_mode[i] = 'x; log_lyr[i] = 'x;
        end
        done_cnt = 0; done_idx = -1; wr_cnt = 0; rd_cnt = 0; align_err = 0; mode2_cnt = 0;
        q.delete();
        @(negedge clk);
        start = 1'b1;
        inv   = iv;
        @(posedge clk);
        #1;
        acc    = gcyc;
        log_on = 1;
        start  = 1'b0;
        inv    = ~iv;
    endtask

    task automatic finish_run();
        int k = 0;
        while (done_cnt == 0 && k < 1300) begin
            @(negedge clk);
            k++;
        end
        check("done_before_timeout", done_cnt != 0, 1);
        repeat (20) @(negedge clk);
    endtask

    task automatic check_vectors(input bit iv);
        foreach (vecs[i]) begin
            if (vecs[i].iv == iv) begin
                check($sformatf("v%0d_i%0d_rd_en", i, vecs[i].idx), log_rd[vecs[i].idx], vecs[i].rd);
                if (vecs[i].rd) begin
                    check($sformatf("v%0d_i%0d_rd_addr_a", i, vecs[i].idx), log_a[vecs[i].idx], vecs[i].a);
                    check($sformatf("v%0d_i%0d_rd_addr_b", i, vecs[i].idx), log_b[vecs[i].idx], vecs[i].b);
                    check($sformatf("v%0d_i%0d_tw_addr", i, vecs[i].idx), log_tw[vecs[i].idx], vecs[i].tw);
                    check($sformatf("v%0d_i%0d_bf_mode", i, vecs[i].idx), log_mode[vecs[i].idx], vecs[i].mode);
                end
                check($sformatf("v%0d_i%0d_layer", i, vecs[i].idx), log_lyr[vecs[i].idx], vecs[i].lyr);
            end
        end
    endtask

    initial begin
        // Layer l, butterfly j appears at period index l*132 + j.
        add(0,   0, 1,   0, 128,   1, 0, 0);
        add(0,   5, 1,   5, 133,   1, 0, 0);
        add(0, 127, 1, 127, 255,   1, 0, 0);
        add(0, 128, 0,   0,   0,   0, 0, 0);
        add(0, 132, 1,   0,  64,   2, 0, 1);
        add(0, 202, 1, 134, 198,   3, 0, 1);
        add(0, 305, 1,  73, 105,   5, 0, 2);
        add(0, 433, 1,  69,  85,  10, 0, 3);
        add(0, 792, 1,   0,   2,  64, 0, 6);
        add(0, 919, 1, 253, 255, 127, 0, 6);
        add(0, 923, 0,   0,   0,   0, 0, 6);
        add(0, 925, 0,   0,   0,   0, 0, 0);
        add(1,   0, 1,   0,   2, 127, 1, 0);
        add(1,   1, 1,   1,   3, 127, 1, 0);
        add(1,   2, 1,   4,   6, 126, 1, 0);
        add(1, 127, 1, 253, 255,  64, 1, 0);
        add(1, 301, 1,  69,  77,  27, 1, 2);
        add(1, 792, 1,   0, 128,   1, 1, 6);
        add(1, 919, 1, 127, 255,   1, 1, 6);
`ifdef NTT_CTRL_INTT_SCALE_EN
        add(1,  924, 1,   0,   1, 0, 2, 6);
        add(1,  929, 1,  10,  11, 0, 2, 6);
        add(1, 1051, 1, 254, 255, 0, 2, 6);
        add(1, 1052, 0,   0,   0, 0, 0, 6);
        add(1, 1057, 0,   0,   0, 0, 0, 0);
`else
        add(1,  925, 0,   0,   0, 0, 0, 0);
`endif

        rst_n = 1'b1; start = 1'b0; inv = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {busy, done, rd_en, wr_en, bf_mode, layer, tw_addr}, 0);
        check("reset_addr", {rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_rd_en", rd_en, 0);

        // Forward NTT, with a start/inv pulse while busy that must be ignored.
        begin_run(0);
        repeat (300) @(negedge clk);
        start = 1'b1; inv = 1'b1;
        @(negedge clk);
        start = 1'b0; inv = 1'b0;
        finish_run();
        check_vectors(0);
        check("ntt_done_idx", done_idx, 924);
        check("ntt_done_cnt", done_cnt, 1);
        check("ntt_rd_cnt", rd_cnt, 896);
        check("ntt_wr_cnt", wr_cnt, 896);
        check("ntt_align_err", align_err, 0);
        check("ntt_mode2_cnt", mode2_cnt, 0);
        check("ntt_busy_after", busy, 0);

        // Inverse transform.
        begin_run(1);
        finish_run();
        check_vectors(1);
        check("intt_done_idx", done_idx, INTT_DONE);
        check("intt_done_cnt", done_cnt, 1);
        check("intt_wr_cnt", wr_cnt, INTT_WR);
        check("intt_align_err", align_err, 0);
        check("intt_mode2_cnt", mode2_cnt, INTT_M2);

        // Reset in layer 3; 484 writes have landed by then (3*128 + 100).
        begin_run(0);
        repeat (500) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_rd_en", rd_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_wr_cnt", wr_cnt, 484);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold_ctrl", {busy, done, rd_en, wr_en, bf_mode, layer, tw_addr}, 0);
        check("rst_hold_addr", {rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b}, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_wr_cnt", wr_cnt, 484);
        check("post_rst_done_cnt", done_cnt, 0);
        check("post_rst_busy", busy, 0);

        begin_run(0);
        finish_run();
        check("rerun_done_idx", done_idx, 924);
        check("rerun_done_cnt", done_cnt, 1);
        check("rerun_wr_cnt", wr_cnt, 896);
        check("rerun_align_err", align_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
